// File: rtl/adq_pkg.sv
// Shared definitions for the temperature acquisition front end.
// TEMP_W must stay equal to the temperatura width used by union_1.
package adq_pkg;

  localparam int DIV_DEF      = 4;
  localparam int N_BITS_DEF   = 8;
  localparam int AVG_LOG2_DEF = 2;
  localparam int TEMP_W       = 5;

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    PREP   = 3'd1,
    SHIFT  = 3'd2,
    FIN    = 3'd3,
    GUARDA = 3'd4,
    SALIDA = 3'd5
  } adq_state_t;

  // True while a serial frame is in progress (the sclk divider only runs here)
  function automatic logic is_framing(input adq_state_t s);
    return (s == PREP) || (s == SHIFT) || (s == FIN);
  endfunction

endpackage

// File: rtl/adq_temperatura_div_sclk.sv
// Half-period divider for the ADC serial clock.
// tick marks the last system cycle of each DIV-cycle half-period.
// rise marks a tick that ends a low half, i.e. sclk is about to go 0->1.
// restart realigns the phase so every FSM state starts on a fresh low half.
module div_sclk #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick,
  output logic rise
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;

  assign tick = en && (cnt == CW'(DIV - 1));
  assign rise = tick && !phase;

  // Phase counter and half-period parity; idle and restart both return to a low half
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en || restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adq_temperatura.sv
// Acquisition stage for the temperature controller: reads an 8-bit serial
// ADC over cs_n/sclk/sdata, averages 2^AVG_LOG2 conversions and publishes
// the top TEMP_W bits of the mean on temperatura with a one-cycle lect.
// temperatura and lect are loaded together so lect always qualifies the
// freshly updated code.
module adq_temperatura
  import adq_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int N_BITS   = N_BITS_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_m1,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [TEMP_W-1:0] temperatura,
  output logic              lect
);

  localparam int BCW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SCW   = AVG_LOG2 + 1;
  localparam int ACC_W = N_BITS + AVG_LOG2;

  adq_state_t state, next_state;

  logic              tick;
  logic              rise;
  logic              div_en;
  logic              restart;
  logic              cs_n_next;
  logic              sclk_next;

  logic [N_BITS-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;
  logic [SCW-1:0]    sample_cnt;
  logic [SCW-1:0]    sample_next;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [TEMP_W-1:0] temp_code;
  logic              last_bit;
  logic              last_sample;

  assign div_en  = is_framing(state);
  assign restart = (next_state != state);

  div_sclk #(.DIV(DIV)) u_div (
    .clock   (clock),
    .reset   (reset),
    .en      (div_en),
    .restart (restart),
    .tick    (tick),
    .rise    (rise)
  );

  assign last_bit    = (bit_cnt == BCW'(N_BITS - 1));
  assign sample_next = sample_cnt + 1'b1;
  assign last_sample = (sample_next == SCW'(2 ** AVG_LOG2));
  assign acc_sum     = acc + ACC_W'(shreg);
  // Mean is acc_sum >> AVG_LOG2; keep its top TEMP_W bits
  assign temp_code   = TEMP_W'(acc_sum >> (AVG_LOG2 + N_BITS - TEMP_W));

  // Next-state decode plus the next values of the registered link outputs
  always_comb begin
    next_state = state;
    sclk_next  = 1'b0;
    cs_n_next  = 1'b1;
    unique case (state)
      REPOSO: if (en_m1) next_state = PREP;
      PREP:   if (tick) next_state = SHIFT;
      SHIFT: begin
        sclk_next = sclk;
        if (tick) begin
          sclk_next = rise;
          if (!rise && last_bit) next_state = FIN;
        end
      end
      FIN:    if (tick) next_state = GUARDA;
      GUARDA: begin
        if (last_sample)  next_state = SALIDA;
        else if (en_m1)   next_state = PREP;
        else              next_state = REPOSO;
      end
      SALIDA: next_state = en_m1 ? PREP : REPOSO;
      default: next_state = REPOSO;
    endcase
    cs_n_next = !((next_state == PREP) || (next_state == SHIFT));
  end

  // State register and glitch-free flop-driven cs_n/sclk
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= REPOSO;
      cs_n  <= 1'b1;
      sclk  <= 1'b0;
    end else begin
      state <= next_state;
      cs_n  <= cs_n_next;
      sclk  <= sclk_next;
    end
  end

  // Shift-in, bit/sample counting, accumulation and result publication
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      sample_cnt  <= '0;
      acc         <= '0;
      temperatura <= '0;
      lect        <= 1'b0;
    end else begin
      lect <= 1'b0;
      case (state)
        REPOSO: begin
          acc        <= '0;
          sample_cnt <= '0;
          bit_cnt    <= '0;
        end
        PREP: bit_cnt <= '0;
        SHIFT: begin
          if (tick) begin
            if (rise) shreg   <= {shreg[N_BITS-2:0], sdata};
            else      bit_cnt <= bit_cnt + 1'b1;
          end
        end
        GUARDA: begin
          if (last_sample) begin
            acc         <= acc_sum;
            sample_cnt  <= sample_next;
            temperatura <= temp_code;
            lect        <= 1'b1;
          end else if (en_m1) begin
            acc        <= acc_sum;
            sample_cnt <= sample_next;
          end else begin
            acc        <= '0;
            sample_cnt <= '0;
          end
        end
        SALIDA: begin
          acc        <= '0;
          sample_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adq_temperatura.md
Name: adq_temperatura

Overview:
- Upstream acquisition stage for the temperature controller (union_1). It reads an external 8-bit serial ADC through a 3-wire SPI-style link (cs_n, sclk, sdata).
- It averages 2^AVG_LOG2 conversions and scales the result to the 5-bit temperatura code the controller consumes.
- Each new value is announced by a one-cycle lect strobe. Acquisition runs continuously while en_m1 is high.

Parameters:
- DIV, 4: system clock cycles per sclk half-period (≥2).
- N_BITS, 8: ADC word width, MSB first.
- AVG_LOG2, 2: log2 of the number of samples averaged (4 samples).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- en_m1  in  1  acquisition enable, level.
- sdata  in  1  ADC serial data, stable around sclk rising edge.
- cs_n  out  1  ADC chip select, active-low.
- sclk  out  1  ADC serial clock, registered.
- temperatura  out  5  averaged temperature code, held between updates.
- lect  out  1  one-cycle pulse: temperatura just updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - cs_n=1, sclk=0, temperatura=0, lect=0.
  - Shift register, bit counter, sample counter and accumulator cleared; state REPOSO.
  - Reset mid-frame aborts the frame immediately; there is no partial accumulate.
- FSM states: REPOSO, PREP, SHIFT, FIN, GUARDA, SALIDA.
- REPOSO:
  - cs_n=1, sclk=0.
  - en_m1=1 sampled → PREP next cycle; the accumulator and sample count are cleared on entry.
- PREP: cs_n=0 for DIV cycles (setup), sclk=0 → SHIFT.
- SHIFT:
  - N_BITS sclk periods, each DIV cycles low then DIV cycles high.
  - sdata is captured into the shift register in the cycle sclk goes 0→1, MSB first.
  - After the Nth high phase: sclk=0 → FIN.
- FIN: cs_n=1 for DIV cycles (quiet time) → GUARDA.
- GUARDA (1 cycle):
  - acc += sample; acc width is N_BITS+AVG_LOG2, so there is no overflow.
  - sample_cnt++.
  - If sample_cnt reaches 2^AVG_LOG2 → SALIDA.
  - Else if en_m1=1 → PREP.
  - Else → REPOSO, and the partial accumulator is discarded.
- SALIDA (1 cycle):
  - temperatura <= (acc >> AVG_LOG2) >> (N_BITS-5), i.e. the truncated top 5 bits of the mean.
  - lect=1 in this cycle only.
  - acc and sample_cnt cleared.
  - Next state: PREP if en_m1=1, else REPOSO.
- Frame length: DIV + 2·DIV·N_BITS + DIV + 1 cycles, which is 73 cycles at the defaults.
- Latency: lect fires 4·73+1 = 293 cycles after leaving REPOSO (defaults).
- en_m1 falling mid-frame: the current frame completes and is accumulated; then REPOSO, with no lect unless that frame was the 4th.
- temperatura holds its value through REPOSO and en_m1 toggling; only SALIDA or reset changes it.
- sclk and cs_n are driven directly from flops (glitch-free). cs_n never changes while sclk=1.

Decomposition:
- Shared package adq_pkg holds:
  - FSM state encoding (3-bit localparams for REPOSO..SALIDA).
  - Default DIV/N_BITS/AVG_LOG2.
  - TEMP_W=5, shared with union_1's temperatura width.
- One sub-module, div_sclk: DIV-cycle phase counter producing a tick at each half-period end plus a rise flag. It is enabled only in PREP/SHIFT/FIN.

Test Plan:
- Constant ADC model 0xA0, en_m1=1 after reset release:
  - Exactly 8 sclk rising edges per cs_n-low window.
  - sclk period = 8 clocks.
  - First lect 293 cycles after start, with temperatura=20.
- Samples 0x50, 0x58, 0x60, 0x68 → mean 0x5C=92 → temperatura=11 on lect. Next window all 0xFF → temperatura=31.
- Drop en_m1 during the 2nd frame's SHIFT:
  - The frame completes, then cs_n stays 1 and sclk stays 0 with no lect.
  - Re-enable → 4 fresh frames before the next lect; the old partial sum is not used.
- Assert reset mid-SHIFT:
  - cs_n=1, sclk=0, lect=0 and temperatura=0 in the same cycle (asynchronous).
  - After release with en_m1=1, a full 293-cycle sequence follows.
- Bit-order and sample-point check: ADC model drives 0x81 and changes sdata only while sclk=0. The captured sample is 0x81, not 0x03 or 0x40.
- Chain with union_1 (temperatura/lect connected), ADC ramp mapping to 10, 20, 25, 28, 30: each lect delivers the matching code and union_1's estados follows.
